// File: rtl/drive_sched.sv
// rtl/drive_sched.sv - assist-current scheduler with one shared multiplier
// Optional feature macro: RAMP_LIMIT_EN (slew-limits target_curr by MAX_STEP per update)

module drive_sched #(
  parameter logic [11:0] TORQUE_MIN = 12'h380
`ifdef RAMP_LIMIT_EN
  ,
  parameter logic [11:0] MAX_STEP = 12'd64
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        smpl_vld,
  input  logic [11:0] avg_torque,
  input  logic [4:0]  cadence,
  input  logic        not_pedaling,
  input  logic [12:0] incline,
  input  logic [2:0]  scale,
  output logic [11:0] target_curr,
  output logic        curr_vld,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    MUL3 = 3'd4,
    SAT  = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  // Shadow copy of the sample being computed; stable for the whole sequence.
  logic [11:0] sh_torque;
  logic [4:0]  sh_cadence;
  logic        sh_np;
  logic [12:0] sh_incline;
  logic [2:0]  sh_scale;

  // One-deep holding slot for a sample that arrived while busy (newest wins).
  logic [11:0] pd_torque;
  logic [4:0]  pd_cadence;
  logic        pd_np;
  logic [12:0] pd_incline;
  logic [2:0]  pd_scale;
  logic        pend;

  // Operands registered in PREP.
  logic [11:0] torque_pos;
  logic [8:0]  incline_lim;
  logic [5:0]  cadence_factor;

  // Running product; after MUL2 it never exceeds 27 bits.
  logic [26:0] p;

  // Combinational operand preparation.
  logic [12:0]        torque_diff;
  logic signed [12:0] incline_s;
  logic signed [12:0] incline_sat;
  logic signed [12:0] incline_off;
  logic [11:0]        torque_pos_c;
  logic [8:0]         incline_lim_c;
  logic [5:0]         cadence_factor_c;

  // Shared multiplier.
  logic [26:0] mul_a;
  logic [8:0]  mul_b;
  logic [29:0] mul_out;

  // Final result.
  logic [11:0] res_sat;
  logic [11:0] res_final;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: fixed six-step sequence, started by a new or pending sample.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (smpl_vld || pend) state_nxt = PREP;
      PREP:    state_nxt = MUL1;
      MUL1:    state_nxt = MUL2;
      MUL2:    state_nxt = MUL3;
      MUL3:    state_nxt = SAT;
      SAT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; target_curr is written on entry to SAT.
  always_comb begin
    busy     = (state != IDLE);
    curr_vld = (state == SAT);
  end

  // Operand conditioning from the shadow sample.
  always_comb begin
    torque_diff  = {1'b0, sh_torque} - {1'b0, TORQUE_MIN};
    torque_pos_c = torque_diff[12] ? 12'd0 : torque_diff[11:0];

    incline_s = sh_incline;
    if (incline_s > 13'sd511)       incline_sat = 13'sd511;
    else if (incline_s < -13'sd512) incline_sat = -13'sd512;
    else                            incline_sat = incline_s;
    incline_off = incline_sat + 13'sd256;
    if (incline_off < 13'sd0)        incline_lim_c = 9'd0;
    else if (incline_off > 13'sd511) incline_lim_c = 9'd511;
    else                             incline_lim_c = incline_off[8:0];

    cadence_factor_c = (sh_cadence > 5'd1) ? ({1'b0, sh_cadence} + 6'd32) : 6'd0;
  end

  // Operand mux for the single multiplier.
  always_comb begin
    mul_a = 27'd0;
    mul_b = 9'd0;
    case (state)
      MUL1: begin
        mul_a = {15'd0, torque_pos};
        mul_b = incline_lim;
      end
      MUL2: begin
        mul_a = {6'd0, p[20:0]};
        mul_b = {3'd0, cadence_factor};
      end
      MUL3: begin
        mul_a = p;
        mul_b = {6'd0, sh_scale};
      end
      default: begin
        mul_a = 27'd0;
        mul_b = 9'd0;
      end
    endcase
    mul_out = {3'd0, mul_a} * {21'd0, mul_b};
  end

  // Saturation, pedal override and optional slew limit of the final product.
  always_comb begin
    res_sat = (|mul_out[29:27]) ? 12'hFFF : mul_out[26:15];
    if (sh_np) res_sat = 12'd0;
`ifdef RAMP_LIMIT_EN
    if ({1'b0, res_sat} > ({1'b0, target_curr} + {1'b0, MAX_STEP}))
      res_final = target_curr + MAX_STEP;
    else if (({1'b0, res_sat} + {1'b0, MAX_STEP}) < {1'b0, target_curr})
      res_final = target_curr - MAX_STEP;
    else
      res_final = res_sat;
`else
    res_final = res_sat;
`endif
  end

  // Sample capture, pending slot, operand registers, product and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_torque      <= 12'd0;
      sh_cadence     <= 5'd0;
      sh_np          <= 1'b0;
      sh_incline     <= 13'd0;
      sh_scale       <= 3'd0;
      pd_torque      <= 12'd0;
      pd_cadence     <= 5'd0;
      pd_np          <= 1'b0;
      pd_incline     <= 13'd0;
      pd_scale       <= 3'd0;
      pend           <= 1'b0;
      torque_pos     <= 12'd0;
      incline_lim    <= 9'd0;
      cadence_factor <= 6'd0;
      p              <= 27'd0;
      target_curr    <= 12'd0;
    end else begin
      if (state == IDLE) begin
        if (smpl_vld) begin
          sh_torque  <= avg_torque;
          sh_cadence <= cadence;
          sh_np      <= not_pedaling;
          sh_incline <= incline;
          sh_scale   <= scale;
          pend       <= 1'b0;
        end else if (pend) begin
          sh_torque  <= pd_torque;
          sh_cadence <= pd_cadence;
          sh_np      <= pd_np;
          sh_incline <= pd_incline;
          sh_scale   <= pd_scale;
          pend       <= 1'b0;
        end
      end else if (smpl_vld) begin
        pd_torque  <= avg_torque;
        pd_cadence <= cadence;
        pd_np      <= not_pedaling;
        pd_incline <= incline;
        pd_scale   <= scale;
        pend       <= 1'b1;
      end

      case (state)
        PREP: begin
          torque_pos     <= torque_pos_c;
          incline_lim    <= incline_lim_c;
          cadence_factor <= cadence_factor_c;
        end
        MUL1, MUL2: p <= mul_out[26:0];
        MUL3: begin
          p           <= mul_out[26:0];
          target_curr <= res_final;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/drive_sched.md
Name: drive_sched

Overview:
- Sequential, resource-shared implementation of the assist-current computation for the e-bike motor drive.
- Accepts one sensor sample per `smpl_vld` strobe and computes target current as torque_pos × incline_lim × cadence_factor × scale. All three multiplies run on one shared multiplier over successive cycles.
- Sits between the sensor-conditioning blocks (torque averager, cadence meter, inclinometer) and the motor PI/current loop. Emits a one-cycle `curr_vld` with each new result.

Parameters:
- TORQUE_MIN, 12'h380, torque offset subtracted from avg_torque before the multiply.
- MAX_STEP, 12'd64, maximum change of target_curr per update. Used only when RAMP_LIMIT_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- smpl_vld  input  1  one-cycle strobe; sample inputs are valid this cycle.
- avg_torque  input  12  unsigned averaged pedal torque.
- cadence  input  5  unsigned cadence count.
- not_pedaling  input  1  when high, the result is forced to 0.
- incline  input  13  signed incline.
- scale  input  3  unsigned assist level.
- target_curr  output  12  registered target motor current.
- curr_vld  output  1  one-cycle pulse; target_curr was updated this cycle.
- busy  output  1  high while any state other than IDLE is active.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous, active-high.
- Reset values: target_curr=0, curr_vld=0, busy=0, state=IDLE, pending flag cleared. Reset asserted mid-sequence aborts the computation. No curr_vld is produced for the aborted sample.
- FSM states: IDLE -> PREP -> MUL1 -> MUL2 -> MUL3 -> SAT -> IDLE.
- IDLE:
  - On smpl_vld, latch all sample inputs into shadow registers and go to PREP.
  - Otherwise, if the pending flag is set, load the pending registers and go to PREP.
- PREP (registers the three operands):
  - incline_sat = incline saturated to the signed range [-512, 511].
  - incline_lim = clamp(incline_sat + 256, 0, 511), 9 bits unsigned.
  - cadence_factor = (cadence > 1) ? cadence + 32 : 0, 6 bits.
  - torque_pos = max(avg_torque - TORQUE_MIN, 0), 12 bits; compute the subtraction at 13 bits.
- Shared multiplier: exactly one multiplier instance, unsigned 27-bit × 9-bit, operands muxed by state.
  - MUL1: p = torque_pos × incline_lim (21 bits).
  - MUL2: p = p × cadence_factor (27 bits).
  - MUL3: p = p × scale (30 bits).
- SAT:
  - If p[29:27] is nonzero, target_curr = 12'hFFF; else target_curr = p[26:15].
  - If the latched not_pedaling is 1, target_curr = 0.
  - Assert curr_vld for this cycle, then return to IDLE.
- Latency: smpl_vld accepted in IDLE at cycle N -> target_curr updated and curr_vld high at cycle N+5. Throughput is one sample per 6 cycles (back-to-back via pending).
- smpl_vld while busy: capture the sample into one-deep pending registers and set the pending flag.
  - A later smpl_vld while pending is set overwrites the pending sample (newest wins); the older pending sample is dropped.
  - Pending is consumed on the first IDLE cycle after SAT.
- smpl_vld in the same cycle as SAT: captured into pending. Sequence restarts after one IDLE cycle.
- smpl_vld in IDLE with pending set: new sample wins, pending flag cleared.
- Between updates, target_curr holds its value.
- Zero operands still run the full sequence; latency is constant.

Optional Feature:
- Macro: RAMP_LIMIT_EN.
- Defined: in SAT, the saturated/forced result r is slew-limited:
  - if r > target_curr + MAX_STEP, target_curr += MAX_STEP;
  - if r < target_curr - MAX_STEP, target_curr -= MAX_STEP;
  - otherwise target_curr = r.
  - Comparisons use 13-bit arithmetic, so there is no wrap at 0 or 0xFFF. not_pedaling ramps down rather than dropping.
  - curr_vld still pulses on every update. Latency is unchanged.
- Undefined: target_curr = r directly. MAX_STEP is unused.

Test Plan:
- Nominal: avg_torque=0x780, incline=0, cadence=16, scale=3, smpl_vld at N -> busy high for N+1..N+5, curr_vld only at N+5, target_curr=0x480.
- Saturation: avg_torque=0xFFF, incline=13'h0FFF, cadence=31, scale=7 -> target_curr=0xFFF (p=720897849 ≥ 2^27).
- Zero paths, each from a nonzero prior result -> target_curr=0:
  - incline=-300, others nominal;
  - cadence=1;
  - avg_torque=0x300;
  - not_pedaling=1.
- Overlap: nominal sample at N, scale=1 sample at N+2, scale=2 sample at N+3 -> first result 0x480 at N+5; scale=2 result 0x300 at N+11; scale=1 sample never produces a curr_vld.
- Reset mid-op: rst at N+3 after nominal smpl_vld at N -> no curr_vld, target_curr=0, busy=0 from the cycle after rst. A new sample is then accepted normally.
- RAMP_LIMIT_EN defined: from 0, nominal sample repeated four times -> target_curr=0x040, 0x080, 0x0C0, 0x100; then not_pedaling=1 -> 0x0C0.
